// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target: single-address I2C target (slave), oversampled on clk.
//
// Ports:
//   clk       system clock, at least 8x SCL
//   reset     asynchronous active-low reset
//   scl_in    bus SCL level
//   sda_in    bus SDA level
//   sda_oe    1 = pull SDA low (top level: sda = sda_oe ? 1'b0 : 1'bz)
//   tx_data   byte returned on a read, captured when tx_load pulses
//   tx_load   one-clk pulse when tx_data is captured
//   rx_data   last byte received in a write, held until the next byte
//   rx_valid  one-clk pulse when rx_data updates
//   addr_hit  one-clk pulse on address match
//   busy      high from address match until STOP, NACK or START
//
// SCL/SDA pass through a 2-flop synchronizer plus one history flop, so every
// bus event acts 3 clk after the pin edge. SCL is never driven.
// -----------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // NOTE: synchronizers reset to 1 so a reset never fabricates a START/STOP
  // or an SCL edge on an idle (pulled-up) bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q &  scl_prev_q;
  assign start_det =  scl_sync_q &  sda_prev_q & ~sda_sync_q;
  assign stop_det  =  scl_sync_q & ~sda_prev_q &  sda_sync_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  // Marks that the current phase has seen its last scl_rise (8th data bit
  // or master ACK), so the following scl_fall closes the phase.
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; the async clear also releases SDA without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rw_q       <= 1'b0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    addr_hit_d = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      done_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == ADDR) begin
              sda_oe_d   = 1'b1;
              addr_hit_d = 1'b1;
              busy_d     = 1'b1;
              rw_d       = shift_q[0];
              state_d    = S_ADDR_ACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              tx_load_d = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              state_d   = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_sync_q};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          // The MSB is already on the bus; each fall moves to the next bit.
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_sync_q) begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            tx_load_d = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = S_RD_DATA;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule
